alu_result_uart_tx: RTL and testbench

//   Transmit side of the ALU result path: captures the 8-bit ALU result and its
//   4 flags on a request strobe and sends them as a 2-byte UART 8N1 frame.

---
 rtl/alu_result_uart_tx.sv | 146 ++++++++++++++
 tb/tb_alu_result_uart_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_uart_tx.sv
// UART 8N1 transmitter for the ALU result path: one send request captures the
// result byte and a flags byte ({4'hA, flags}) and shifts both out back-to-back.
module alu_result_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] resultado,
    input  logic [3:0] flags,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic          byte_idx_reg, byte_idx_next;
    logic [7:0]    byte0_reg, byte0_next;
    logic [7:0]    byte1_reg, byte1_next;
    logic          tx_reg, tx_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;

    logic          timer_wrap;
    logic [7:0]    byte_sel_next;

    assign timer_wrap = (timer_reg == TIMER_LAST);

    // Byte that will be on the line after this edge, so tx can be registered
    // with the bit it must carry during the coming cycle.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte_sel
            assign byte_sel_next[gi] = byte_idx_next ? byte1_next[gi] : byte0_next[gi];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        bit_idx_next  = bit_idx_reg;
        byte_idx_next = byte_idx_reg;
        byte0_next    = byte0_reg;
        byte1_next    = byte1_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (send) begin
                    state_next    = START;
                    timer_next    = '0;
                    bit_idx_next  = 3'd0;
                    byte_idx_next = 1'b0;
                    byte0_next    = resultado;
                    byte1_next    = {4'hA, flags};
                    busy_next     = 1'b1;
                end
            end
            START: begin
                timer_next = timer_wrap ? '0 : timer_reg + 1'b1;
                if (timer_wrap) begin
                    state_next   = DATA;
                    bit_idx_next = 3'd0;
                end
            end
            DATA: begin
                timer_next = timer_wrap ? '0 : timer_reg + 1'b1;
                if (timer_wrap) begin
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                timer_next = timer_wrap ? '0 : timer_reg + 1'b1;
                if (timer_wrap) begin
                    if (!byte_idx_reg) begin
                        // Flags byte follows immediately, no idle gap.
                        state_next    = START;
                        byte_idx_next = 1'b1;
                        bit_idx_next  = 3'd0;
                    end else begin
                        state_next    = IDLE;
                        byte_idx_next = 1'b0;
                        busy_next     = 1'b0;
                        done_next     = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase

        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = byte_sel_next[bit_idx_next];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            bit_idx_reg  <= 3'd0;
            byte_idx_reg <= 1'b0;
            byte0_reg    <= 8'h00;
            byte1_reg    <= 8'h00;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            bit_idx_reg  <= bit_idx_next;
            byte_idx_reg <= byte_idx_next;
            byte0_reg    <= byte0_next;
            byte1_reg    <= byte1_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    assign tx   = tx_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Self-checking bench for alu_result_uart_tx with 4 clocks per bit: frames are
// sampled on falling edges, decoded, and compared against a scoreboard queue.
module tb_alu_result_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 20 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       send;
    logic [7:0] resultado;
    logic [3:0] flags;
    logic       tx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] res;
        logic [3:0] flg;
        logic [7:0] e0;
        logic [7:0] e1;
        int         mode;   // 0 plain, 1 input change after send, 2 send pulses while busy
        string      name;
    } vec_t;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    alu_result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .send      (send),
        .resultado (resultado),
        .flags     (flags),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive a one-cycle send at a falling edge, record the expectation, and
    // return on the falling edge right after the capturing rising edge.
    task automatic start_send(input logic [7:0] r, input logic [3:0] f,
                              input logic [7:0] e0, input logic [7:0] e1);
        exp_t e;
        resultado = r;
        flags     = f;
        send      = 1'b1;
        e.b0 = e0;
        e.b1 = e1;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Sample one full frame starting at the current falling edge (start bit,
    // cycle 0), then check the completion cycle and decode the bytes.
    task automatic recv_frame(input int mode, input string nm);
        logic       txs[FRAME];
        int         busy_cnt;
        int         done_cnt;
        int         glitch;
        logic       framing;
        logic [7:0] b0;
        logic [7:0] b1;
        exp_t       e;
        busy_cnt = 0;
        done_cnt = 0;
        glitch   = 0;
        for (int i = 0; i < FRAME; i++) begin
            txs[i] = tx;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            send = (mode == 3) || (mode == 2 && (i == 10 || i == 50));
            if (mode == 1 && i == 0) begin
                resultado = 8'hFF;
                flags     = 4'hF;
            end
            @(negedge clk);
        end
        check({nm, " busy_cycles"}, busy_cnt, FRAME);
        check({nm, " done_in_frame"}, done_cnt, 0);
        check({nm, " end_busy"}, {31'd0, busy}, 0);
        check({nm, " end_done"}, {31'd0, done}, 1);
        check({nm, " end_tx"}, {31'd0, tx}, 1);
        for (int k = 0; k < 20; k++) begin
            for (int j = 1; j < CPB; j++) begin
                if (txs[k*CPB+j] !== txs[k*CPB]) glitch++;
            end
        end
        check({nm, " bit_stability"}, glitch, 0);
        framing = (txs[0] === 1'b0) && (txs[9*CPB] === 1'b1) &&
                  (txs[10*CPB] === 1'b0) && (txs[19*CPB] === 1'b1);
        check({nm, " framing"}, {31'd0, framing}, 1);
        for (int d = 0; d < 8; d++) begin
            b0[d] = txs[(1 + d) * CPB + CPB / 2];
            b1[d] = txs[(11 + d) * CPB + CPB / 2];
        end
        if (sb.size() == 0) begin
            check({nm, " scoreboard_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({nm, " byte0"}, {24'd0, b0}, {24'd0, e.b0});
            check({nm, " byte1"}, {24'd0, b1}, {24'd0, e.b1});
            $display("frame %s: byte0=%02h (exp %02h) byte1=%02h (exp %02h)", nm, b0, e.b0, b1, e.b1);
        end
    endtask

    initial begin
        int dcnt;
        vecs[0] = '{8'h3C, 4'b1010, 8'h3C, 8'hAA, 0, "single"};
        vecs[1] = '{8'h3C, 4'b1010, 8'h3C, 8'hAA, 1, "freeze"};
        vecs[2] = '{8'h3C, 4'b1010, 8'h3C, 8'hAA, 2, "send_busy"};
        vecs[3] = '{8'h81, 4'b0101, 8'h81, 8'hA5, 0, "pat81"};
        vecs[4] = '{8'h00, 4'b0000, 8'h00, 8'hA0, 0, "zeros"};
        vecs[5] = '{8'hFF, 4'b1111, 8'hFF, 8'hAF, 0, "ones"};

        rst = 1'b1;
        send = 1'b0;
        resultado = 8'h00;
        flags = 4'h0;
        for (int i = 0; i < 3; i++) begin
            send      = 1'($urandom);
            resultado = 8'($urandom);
            flags     = 4'($urandom);
            @(negedge clk);
            check("reset_tx", {31'd0, tx}, 1);
            check("reset_busy", {31'd0, busy}, 0);
            check("reset_done", {31'd0, done}, 0);
            $display("reset cycle %0d: tx=%b busy=%b done=%b", i, tx, busy, done);
        end
        send = 1'b0;
        rst  = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            start_send(vecs[v].res, vecs[v].flg, vecs[v].e0, vecs[v].e1);
            recv_frame(vecs[v].mode, vecs[v].name);
            send = 1'b0;
            repeat (2) @(negedge clk);
            check({vecs[v].name, " idle_after"}, {31'd0, busy}, 0);
        end

        // Held send: second start bit one cycle after the done pulse.
        start_send(8'h5A, 4'b0011, 8'h5A, 8'hA3);
        recv_frame(3, "held1");
        sb.push_back('{8'h5A, 8'hA3});
        @(negedge clk);
        recv_frame(3, "held2");
        send = 1'b0;
        repeat (2) @(negedge clk);
        check("held_idle_after", {31'd0, busy}, 0);

        // Mid-frame reset during byte0 data bits.
        start_send(8'hC3, 4'b1001, 8'hC3, 8'hA9);
        send = 1'b0;
        repeat (16) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", {31'd0, tx}, 1);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_done", {31'd0, done}, 0);
        $display("mid-frame reset: tx=%b busy=%b done=%b", tx, busy, done);
        rst = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
        dcnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1 || tx !== 1'b1) dcnt++;
        end
        check("midrst_quiet", dcnt, 0);
        start_send(8'h3C, 4'b1010, 8'h3C, 8'hAA);
        recv_frame(0, "after_reset");
        send = 1'b0;
        repeat (2) @(negedge clk);

        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
